cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  2-way set-associative, write-back, write-allocate cache controller. Sits between a CPU request port
//  and a line-wide main-memory port. Holds 512 sets x 2 ways of 128-bit lines with per-way
//  valid/dirty bits and per-set LRU.
//  Address split: tag=addr[31:13] (19b), index=addr[12:4] (9b), offset=addr[3:0].
// PARAMETERS
//  ADDR_W  32   CPU/memory address width
//  LINE_W  128  cache line / memory beat width
//  WORD_W  32   CPU read-data width
//  INDEX_W 9    set index bits (512 sets)
//  TAG_W   19   tag bits = ADDR_W-INDEX_W-4
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       reset, asynchronous, active-low
//  cpu_req_addr    in   32      request byte address
//  cpu_req_datain  in   128     full-line write data
//  cpu_req_dataout out  32      read word = line[offset[3:2]*32 +: 32]
//  cpu_req_rw      in   1       1=write, 0=read
//  cpu_req_valid   in   1       request strobe; sampled only when cache_ready=1
//  cache_ready     out  1       1=idle, accepts a request
//  mem_req_addr    out  32      line address {4'b0,tag,index}
//  mem_req_datain  in   128     line returned by memory
//  mem_req_dataout out  128     victim line on write-back
//  mem_req_rw      out  1       1=write-back, 0=line fill
//  mem_req_valid   out  1       one-cycle request pulse
//  mem_req_ready   in   1       memory busy=0 / done=1
//  state_mode      out  32(int) 0=idle, 1=hit, 2=miss with clean/invalid victim, 3=miss with dirty victim
// BEHAVIOUR
//  - Reset (async, rst_n=0): all valid/dirty/LRU cleared, FSM=IDLE, cache_ready=1, all other outputs 0.
//    Reset mid-operation aborts without write-back.
//  - FSM: IDLE -> COMPARE -> (DONE | WRITEBACK -> WB_WAIT -> ALLOC -> AL_WAIT -> DONE | ALLOC ...) -> IDLE.
//  - Request accept: at the posedge where IDLE and cpu_req_valid=1:
//    - latch addr/rw/data; do tag lookup on the incoming address;
//    - register state_mode (1/2/3) and drop cache_ready at that edge.
//  - Hit: way with valid and matching tag.
//    - Read: cpu_req_dataout valid the following cycle, held until the next read.
//    - Write: replace line, set dirty.
//    - LRU marks the other way.
//    - cache_ready returns after 2 cycles total.
//  - Victim on miss: an invalid way (way0 first), else the LRU way.
//  - Dirty victim: WRITEBACK pulses mem_req_valid for 1 cycle with rw=1, addr=victim line addr,
//    dataout=victim line; WB_WAIT waits for mem_req_ready sampled 0, then sampled 1.
//  - ALLOC, read miss: 1-cycle valid pulse with rw=0, addr=request line; AL_WAIT waits ready 0->1 and
//    captures mem_req_datain in the cycle ready is sampled 1. Line installed valid, clean; data returned.
//  - ALLOC, write miss: no fetch; cpu_req_datain installed valid, dirty.
//  - DONE: update LRU, state_mode<=0, cache_ready<=1.
//  - CPU inputs are ignored while cache_ready=0.
//  - mem_req_valid is never high for two consecutive cycles.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds out ports stat_hits[31:0], stat_misses[31:0]. Saturating counters,
//    +1 per accepted hit/miss, cleared on reset.
//  Not defined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Package cache_pkg:
//    - width localparams, state_e enum, line_t struct {valid,dirty,tag,data};
//    - helper functions tag_of/index_of.
//  Sub-module cache_tag_data_array: 2x512 line_t storage plus 512 LRU bits;
//    - combinational read by index, synchronous write, async clear of valid/dirty/LRU.
//  Controller FSM and muxing live in cache_controller.
// TESTING (memory model: 65536x128, indexed by mem_req_addr)
//  1. Reset, write 0x6B00=0x663322 then 0xEB00=0x444444 -> both ways of set 0xB0 valid+dirty;
//     no mem_req_valid pulses.
//  2. Read 0x6B00, then 0xEB00 -> state_mode=1 each; dataout=0x00663322, then 0x00444444;
//     LRU ends at 0x6B00's way.
//  3. Read 0x2B00 -> state_mode=3; write-back to mem[0x6B0]=0x663322, fill from mem[0x2B0];
//     dataout = word0 of mem[0x2B0].
//  4. Read 0x6B00 -> state_mode=3; mem[0xEB0]=0x444444 written back; line refilled = 0x663322.
//  5. Read 0xAB00 -> state_mode=2 (victim 0x2B00 clean), no write-back.
//     Read 0x2C00 -> state_mode=2 (invalid set 0xC0).
//  6. Assert rst_n=0 during WB_WAIT -> cache_ready=1, mem_req_valid=0, state_mode=0;
//     re-read 0x6B00 -> state_mode=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and line record for the 2-way write-back cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LINE_W    = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned INDEX_W   = 9;
  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - 4;
  localparam int unsigned NUM_SETS  = 1 << INDEX_W;
  localparam int unsigned LINE_BITS = 2 + TAG_W + LINE_W;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StWbWait,
    StAlloc,
    StAlWait,
    StDone
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+3:4];
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [ADDR_W-1:0] addr);
    return line[{addr[3:2], 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_tag_data_array.sv
// Two-way tag/data storage with per-set LRU; combinational read, synchronous write,
// asynchronous clear of valid/dirty/LRU only (tag and data are plain memory).
module cache_tag_data_array
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INDEX_W-1:0]   rd_index,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic                 wr_en,
  input  logic                 wr_way,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 lru_we,
  input  logic                 lru_val,
  output logic [LINE_BITS-1:0] rd_line0,
  output logic [LINE_BITS-1:0] rd_line1,
  output logic                 rd_lru
);

  logic [TAG_W+LINE_W-1:0]   td_mem [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0]  valid_q;
  logic [1:0][NUM_SETS-1:0]  dirty_q;
  logic [NUM_SETS-1:0]       lru_q;
  line_t                     wr_l;
  line_t                     l0;
  line_t                     l1;

  assign wr_l = line_t'(wr_line);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_way][wr_index] <= wr_l.valid;
        dirty_q[wr_way][wr_index] <= wr_l.dirty;
      end
      if (lru_we) begin
        lru_q[wr_index] <= lru_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      td_mem[wr_way][wr_index] <= {wr_l.tag, wr_l.data};
    end
  end

  always_comb begin
    l0.valid           = valid_q[0][rd_index];
    l0.dirty           = dirty_q[0][rd_index];
    {l0.tag, l0.data}  = td_mem[0][rd_index];
    l1.valid           = valid_q[1][rd_index];
    l1.dirty           = dirty_q[1][rd_index];
    {l1.tag, l1.data}  = td_mem[1][rd_index];
  end

  assign rd_line0 = l0;
  assign rd_line1 = l1;
  assign rd_lru   = lru_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-back/write-allocate cache controller FSM.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [LINE_W-1:0] cpu_req_datain,
  output logic [WORD_W-1:0] cpu_req_dataout,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic              cache_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_datain,
  output logic [LINE_W-1:0] mem_req_dataout,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       state_mode
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                rw_q, rw_d;
  logic                way_q, way_d;
  logic [31:0]         mode_q, mode_d;
  logic                seen_low_q, seen_low_d;
  logic [WORD_W-1:0]   dataout_q, dataout_d;

  logic [INDEX_W-1:0]   rd_index;
  logic [TAG_W-1:0]     look_tag;
  logic [LINE_BITS-1:0] rd_line0, rd_line1;
  logic                 rd_lru;
  line_t                l0, l1, sel_line, victim_line;
  logic                 hit0, hit1, hit, hit_way, victim_way;
  logic                 wr_en, lru_we, lru_val;
  line_t                wr_line;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^addr_q[1:0];

  // Lookup uses the incoming address while idle so the outcome is known at the accept edge.
  assign rd_index = (state_q == StIdle) ? index_of(cpu_req_addr) : index_of(addr_q);
  assign look_tag = (state_q == StIdle) ? tag_of(cpu_req_addr) : tag_of(addr_q);

  cache_tag_data_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (rd_index),
    .wr_index (index_of(addr_q)),
    .wr_en    (wr_en),
    .wr_way   (way_q),
    .wr_line  (wr_line),
    .lru_we   (lru_we),
    .lru_val  (lru_val),
    .rd_line0 (rd_line0),
    .rd_line1 (rd_line1),
    .rd_lru   (rd_lru)
  );

  assign l0          = line_t'(rd_line0);
  assign l1          = line_t'(rd_line1);
  assign hit0        = l0.valid && (l0.tag == look_tag);
  assign hit1        = l1.valid && (l1.tag == look_tag);
  assign hit         = hit0 || hit1;
  assign hit_way     = !hit0;
  assign victim_way  = !l0.valid ? 1'b0 : (!l1.valid ? 1'b1 : rd_lru);
  assign victim_line = victim_way ? l1 : l0;
  assign sel_line    = way_q ? l1 : l0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      way_q      <= 1'b0;
      mode_q     <= '0;
      seen_low_q <= 1'b0;
      dataout_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      way_q      <= way_d;
      mode_q     <= mode_d;
      seen_low_q <= seen_low_d;
      dataout_q  <= dataout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rw_d       = rw_q;
    way_d      = way_q;
    mode_d     = mode_q;
    seen_low_d = seen_low_q;
    dataout_d  = dataout_q;
    wr_en      = 1'b0;
    wr_line    = '0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          data_d  = cpu_req_datain;
          rw_d    = cpu_req_rw;
          way_d   = hit ? hit_way : victim_way;
          mode_d  = hit ? 32'd1 : ((victim_line.valid && victim_line.dirty) ? 32'd3 : 32'd2);
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (mode_q == 32'd1) begin
          if (rw_q) begin
            wr_en   = 1'b1;
            wr_line = '{valid: 1'b1, dirty: 1'b1, tag: tag_of(addr_q), data: data_q};
          end else begin
            dataout_d = word_of(sel_line.data, addr_q);
          end
          state_d = StDone;
        end else if (mode_q == 32'd3) begin
          state_d = StWriteback;
        end else begin
          state_d = StAlloc;
        end
      end
      StWriteback: begin
        seen_low_d = 1'b0;
        state_d    = StWbWait;
      end
      StWbWait: begin
        // Completion needs ready seen low first, then high.
        if (!seen_low_q) begin
          seen_low_d = !mem_req_ready;
        end else if (mem_req_ready) begin
          seen_low_d = 1'b0;
          state_d    = StAlloc;
        end
      end
      StAlloc: begin
        seen_low_d = 1'b0;
        if (rw_q) begin
          wr_en   = 1'b1;
          wr_line = '{valid: 1'b1, dirty: 1'b1, tag: tag_of(addr_q), data: data_q};
          state_d = StDone;
        end else begin
          state_d = StAlWait;
        end
      end
      StAlWait: begin
        if (!seen_low_q) begin
          seen_low_d = !mem_req_ready;
        end else if (mem_req_ready) begin
          seen_low_d = 1'b0;
          wr_en      = 1'b1;
          wr_line    = '{valid: 1'b1, dirty: 1'b0, tag: tag_of(addr_q), data: mem_req_datain};
          dataout_d  = word_of(mem_req_datain, addr_q);
          state_d    = StDone;
        end
      end
      StDone: begin
        lru_we  = 1'b1;
        lru_val = !way_q;
        mode_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_valid   = (state_q == StWriteback) || ((state_q == StAlloc) && !rw_q);
    mem_req_rw      = (state_q == StWriteback) || (state_q == StWbWait);
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    if (mem_req_rw) begin
      mem_req_addr    = {4'b0, sel_line.tag, index_of(addr_q)};
      mem_req_dataout = sel_line.data;
    end else if ((state_q == StAlloc) || (state_q == StAlWait)) begin
      mem_req_addr = {4'b0, tag_of(addr_q), index_of(addr_q)};
    end
  end

  assign cache_ready     = (state_q == StIdle);
  assign cpu_req_dataout = dataout_q;
  assign state_mode      = mode_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if ((state_q == StIdle) && cpu_req_valid) begin
      if (hit) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus queues expected outcomes, a monitor checks
// each completed request; a behavioural line memory answers fills and write-backs.
module tb_cache_controller;

  logic         clk;
  logic         rst_n;
  logic [31:0]  cpu_req_addr;
  logic [127:0] cpu_req_datain;
  logic [31:0]  cpu_req_dataout;
  logic         cpu_req_rw;
  logic         cpu_req_valid;
  logic         cache_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_datain;
  logic [127:0] mem_req_dataout;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  state_mode;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  cache_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_datain  (cpu_req_datain),
    .cpu_req_dataout (cpu_req_dataout),
    .cpu_req_rw      (cpu_req_rw),
    .cpu_req_valid   (cpu_req_valid),
    .cache_ready     (cache_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_datain  (mem_req_datain),
    .mem_req_dataout (mem_req_dataout),
    .mem_req_rw      (mem_req_rw),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .state_mode      (state_mode)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses)
`endif
  );

  typedef struct {
    int          mode;
    bit          is_read;
    logic [31:0] data;
    int          wb;
    int          fill;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] mem [65536];
  bit           mem_stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Memory model: drop ready on a request pulse, complete a few cycles later.
  initial begin
    logic [15:0]  p_addr;
    logic         p_rw;
    logic [127:0] p_data;
    mem_req_ready  = 1'b1;
    mem_req_datain = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid && rst_n) begin
        p_addr        = mem_req_addr[15:0];
        p_rw          = mem_req_rw;
        p_data        = mem_req_dataout;
        mem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        while (mem_stall) @(posedge clk);
        #1;
        if (rst_n) begin
          if (p_rw) mem[p_addr] = p_data;
          else mem_req_datain = mem[p_addr];
        end
        mem_req_ready = 1'b1;
      end
    end
  end

  // Monitor: one scoreboard entry per completed request.
  initial begin
    bit   prev_ready = 1'b1;
    bit   prev_valid = 1'b0;
    bit   busy = 1'b0;
    int   seen_mode = 0;
    int   wb_n = 0;
    int   fill_n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy       = 1'b0;
        prev_ready = 1'b1;
        prev_valid = 1'b0;
      end else begin
        if (prev_ready && !cache_ready) begin
          busy      = 1'b1;
          seen_mode = int'(state_mode);
          wb_n      = 0;
          fill_n    = 0;
        end
        if (mem_req_valid) begin
          check("mem_valid_single_cycle", {127'b0, prev_valid}, 128'd0);
          if (mem_req_rw) wb_n++;
          else fill_n++;
        end
        prev_valid = mem_req_valid;
        if (!prev_ready && cache_ready && busy) begin
          busy = 1'b0;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_completion: got mode %0d, expected no request", seen_mode);
          end else begin
            e = exp_q.pop_front();
            check("state_mode", 128'(seen_mode), 128'(e.mode));
            check("mode_back_to_idle", 128'(state_mode), 128'd0);
            check("writeback_pulses", 128'(wb_n), 128'(e.wb));
            check("fill_pulses", 128'(fill_n), 128'(e.fill));
            if (e.is_read) check("read_data", 128'(cpu_req_dataout), 128'(e.data));
          end
        end
        prev_ready = cache_ready;
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input bit rw, input logic [127:0] data);
    int n = 0;
    while (!cache_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    cpu_req_addr   = addr;
    cpu_req_rw     = rw;
    cpu_req_datain = data;
    cpu_req_valid  = 1'b1;
    @(posedge clk); #1;
    // Garbage while busy must be ignored.
    cpu_req_addr   = 32'hFFFF_FFF0;
    cpu_req_rw     = 1'b1;
    cpu_req_datain = '1;
    @(posedge clk); #1;
    cpu_req_valid  = 1'b0;
  endtask

  task automatic cpu_op(input logic [31:0] addr, input bit rw, input logic [127:0] data,
                        input int mode, input logic [31:0] rdata, input int wb, input int fill);
    int n = 0;
    exp_q.push_back('{mode: mode, is_read: !rw, data: rdata, wb: wb, fill: fill});
    issue(addr, rw, data);
    while (!cache_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cache_ready) begin
      errors++;
      $display("FAIL timeout: cache_ready=%0d after %0d cycles, expected 1", cache_ready, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h02B0] = 128'h2B302B30_2B202B20_2B102B10_2B002B00;
    mem[16'h0AB0] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    mem[16'h02C0] = 128'h2C302C30_2C202C20_2C102C10_2C002C00;
    rst_n          = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_datain = '0;
    cpu_req_rw     = 1'b0;
    cpu_req_valid  = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_cache_ready", 128'(cache_ready), 128'd1);
    check("reset_mem_valid", 128'(mem_req_valid), 128'd0);
    check("reset_state_mode", 128'(state_mode), 128'd0);
    check("reset_dataout", 128'(cpu_req_dataout), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write misses into an empty set: no memory traffic.
    cpu_op(32'h6B00, 1'b1, 128'h663322, 2, 32'h0, 0, 0);
    cpu_op(32'hEB00, 1'b1, 128'h444444, 2, 32'h0, 0, 0);
    // Read hits.
    cpu_op(32'h6B00, 1'b0, '0, 1, 32'h00663322, 0, 0);
    cpu_op(32'hEB00, 1'b0, '0, 1, 32'h00444444, 0, 0);
    // Dirty-victim read misses.
    cpu_op(32'h2B00, 1'b0, '0, 3, 32'h2B002B00, 1, 1);
    check("wb_mem_6B0", mem[16'h06B0], 128'h663322);
    cpu_op(32'h6B00, 1'b0, '0, 3, 32'h00663322, 1, 1);
    check("wb_mem_EB0", mem[16'h0EB0], 128'h444444);
    // Clean-victim and invalid-set misses.
    cpu_op(32'hAB00, 1'b0, '0, 2, 32'hA0A0A0A0, 0, 1);
    cpu_op(32'h2C00, 1'b0, '0, 2, 32'h2C002C00, 0, 1);
    // Hit with nonzero word offset.
    cpu_op(32'hAB0C, 1'b0, '0, 1, 32'hA3A3A3A3, 0, 0);
    // Dirty both ways of set 0xB0, then abort a write-back with reset.
    cpu_op(32'h6B00, 1'b1, 128'h777, 1, 32'h0, 0, 0);
    cpu_op(32'hAB00, 1'b1, 128'h888, 1, 32'h0, 0, 0);
    mem_stall = 1'b1;
    issue(32'h2B00, 1'b0, '0);
    repeat (6) @(posedge clk); #1;
    check("pre_abort_mode", 128'(state_mode), 128'd3);
    check("pre_abort_busy", 128'(cache_ready), 128'd0);
    rst_n = 1'b0;
    #1;
    check("abort_cache_ready", 128'(cache_ready), 128'd1);
    check("abort_mem_valid", 128'(mem_req_valid), 128'd0);
    check("abort_state_mode", 128'(state_mode), 128'd0);
    mem_stall = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_writeback", mem[16'h06B0], 128'h663322);
    cpu_op(32'h6B00, 1'b0, '0, 2, 32'h00663322, 0, 1);

    repeat (5) @(posedge clk); #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
